sram_pb_scrubber: RTL and testbench

- Background scrubber and parity-error logger placed directly in front of a parity-protected 1R1W SRAM read port.
- Multiplexes functional (client) reads with periodic scrub reads that walk every SRAM address.
- Samples the SRAM's combinational parity-error flag and records each failing address and its source in a small error FIFO.
- Maintains a saturating error counter and a sticky overflow flag for software.

---
 rtl/sram_pb_scrubber.sv | 133 +++++++++++++
 tb/tb_sram_pb_scrubber.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pb_scrubber.sv
// Background scrubber and parity-error logger in front of a 1R1W SRAM read port.
// Client reads always win the port; scrub reads walk every address at a programmable interval.
module sram_pb_scrubber #(
    parameter int unsigned SIZE           = 1024,
    parameter int unsigned ADDR_WIDTH     = $clog2(SIZE),
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned COUNT_WIDTH    = 16,
    parameter int unsigned INTERVAL_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      scrub_en,
    input  logic [INTERVAL_WIDTH-1:0] scrub_interval,
    input  logic                      client_read_en,
    input  logic [ADDR_WIDTH-1:0]     client_read_addr,
    output logic                      sram_read_en,
    output logic [ADDR_WIDTH-1:0]     sram_read_addr,
    input  logic                      sram_ecc_pb_error,
    output logic                      client_error,
    output logic                      scrub_pass_done,
    output logic                      err_valid,
    output logic [ADDR_WIDTH-1:0]     err_addr,
    output logic                      err_src,
    input  logic                      err_pop,
    output logic [COUNT_WIDTH-1:0]    err_count,
    output logic                      err_overflow,
    input  logic                      err_clear
);

    localparam int unsigned           PW         = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(SIZE - 1);
    localparam logic [PW:0]           FULL_LEVEL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;

    state_t                    state;
    logic [ADDR_WIDTH-1:0]     scrub_addr;
    logic [INTERVAL_WIDTH-1:0] interval_cnt;
    logic                      scrub_issue;
    logic                      err_event;
    logic                      fifo_full;
    logic                      do_pop;
    logic                      do_push;
    logic                      drop;
    logic [ADDR_WIDTH-1:0]     fifo_addr [FIFO_DEPTH];
    logic                      fifo_src  [FIFO_DEPTH];
    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [PW:0]               level;

    always_comb begin
        scrub_issue    = (state == ISSUE) && scrub_en && !client_read_en;
        sram_read_en   = client_read_en | scrub_issue;
        sram_read_addr = client_read_en ? client_read_addr : scrub_addr;
        err_event      = sram_read_en & sram_ecc_pb_error;
        fifo_full      = (level == FULL_LEVEL);
        err_valid      = (level != '0);
        do_pop         = err_pop & err_valid;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept the push.
        do_push        = err_event & (!fifo_full | do_pop);
        drop           = err_event & fifo_full & !do_pop;
        err_addr       = fifo_addr[rd_ptr];
        err_src        = fifo_src[rd_ptr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            scrub_addr      <= '0;
            interval_cnt    <= '0;
            scrub_pass_done <= 1'b0;
        end else begin
            scrub_pass_done <= 1'b0;
            if (!scrub_en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state        <= WAIT;
                        interval_cnt <= scrub_interval;
                    end
                    WAIT: begin
                        if (interval_cnt == '0) state <= ISSUE;
                        else interval_cnt <= interval_cnt - INTERVAL_WIDTH'(1);
                    end
                    ISSUE: begin
                        if (!client_read_en) begin
                            scrub_addr      <= (scrub_addr == LAST_ADDR) ? '0
                                                                         : scrub_addr + ADDR_WIDTH'(1);
                            scrub_pass_done <= (scrub_addr == LAST_ADDR);
                            interval_cnt    <= scrub_interval;
                            state           <= WAIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_addr[wr_ptr] <= sram_read_addr;
            fifo_src[wr_ptr]  <= !client_read_en;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            err_count    <= '0;
            err_overflow <= 1'b0;
            client_error <= 1'b0;
        end else begin
            client_error <= client_read_en & sram_ecc_pb_error;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)      level <= level + (PW + 1)'(1);
            else if (do_pop && !do_push) level <= level - (PW + 1)'(1);

            if (err_clear) begin
                err_count    <= err_event ? COUNT_WIDTH'(1) : '0;
                err_overflow <= drop;
            end else begin
                if (err_event && (err_count != '1)) err_count <= err_count + COUNT_WIDTH'(1);
                if (drop) err_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_pb_scrubber.sv
// Scoreboard bench for sram_pb_scrubber: expected scrub addresses and error-log entries
// are queued when stimulus is driven and compared as the DUT produces them.
module tb_sram_pb_scrubber;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          scrub_en;
    logic [15:0]   scrub_interval;
    logic          client_read_en;
    logic [AW-1:0] client_read_addr;
    logic          sram_read_en;
    logic [AW-1:0] sram_read_addr;
    logic          sram_ecc_pb_error;
    logic          client_error;
    logic          scrub_pass_done;
    logic          err_valid;
    logic [AW-1:0] err_addr;
    logic          err_src;
    logic          err_pop;
    logic [15:0]   err_count;
    logic          err_overflow;
    logic          err_clear;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          src;
    } entry_t;

    int            total = 0;
    int            bad   = 0;
    entry_t        exp_q[$];
    logic [AW-1:0] exp_rd[$];
    int            m_cnt = 0;
    logic          m_ovf = 1'b0;

    sram_pb_scrubber #(
        .SIZE(16), .FIFO_DEPTH(4), .COUNT_WIDTH(16), .INTERVAL_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset), .scrub_en(scrub_en), .scrub_interval(scrub_interval),
        .client_read_en(client_read_en), .client_read_addr(client_read_addr),
        .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr),
        .sram_ecc_pb_error(sram_ecc_pb_error), .client_error(client_error),
        .scrub_pass_done(scrub_pass_done), .err_valid(err_valid), .err_addr(err_addr),
        .err_src(err_src), .err_pop(err_pop), .err_count(err_count),
        .err_overflow(err_overflow), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One client read with a parity error; optionally pops the head in the same cycle.
    task automatic client_err_cycle(input logic [AW-1:0] a, input logic pop);
        entry_t e;
        client_read_en    = 1'b1;
        client_read_addr  = a;
        sram_ecc_pb_error = 1'b1;
        err_pop           = pop;
        #2;
        if (pop && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (err_addr !== e.addr || err_src !== e.src) begin
                bad++;
                $display("FAIL pop_head: got addr=%0d src=%0b want addr=%0d src=%0b", err_addr, err_src, e.addr, e.src);
            end
        end
        e.addr = a;
        e.src  = 1'b0;
        if (exp_q.size() < 4) exp_q.push_back(e);
        else m_ovf = 1'b1;
        if (m_cnt < 65535) m_cnt++;
        step;
        client_read_en    = 1'b0;
        sram_ecc_pb_error = 1'b0;
        err_pop           = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; scrub_en = 1'b0; scrub_interval = '0;
        client_read_en = 1'b0; client_read_addr = '0; sram_ecc_pb_error = 1'b0;
        err_pop = 1'b0; err_clear = 1'b0;
        step;
        #2;
        total++; if (sram_read_en !== 1'b0) begin bad++; $display("FAIL rst_read_en: got %0b want 0", sram_read_en); end
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL rst_err_valid: got %0b want 0", err_valid); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
        total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %0b want 0", err_overflow); end
        total++; if (client_error !== 1'b0) begin bad++; $display("FAIL rst_client_error: got %0b want 0", client_error); end
        total++; if (scrub_pass_done !== 1'b0) begin bad++; $display("FAIL rst_pass_done: got %0b want 0", scrub_pass_done); end
        step;
        reset = 1'b1;
    endtask

    task automatic test_scrub_walk;
        int passes = 0;
        int cyc = 0;
        int last_t = -1;
        logic prev_issue = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        logic [AW-1:0] e;
        for (int i = 0; i < 16; i++) exp_rd.push_back(AW'(i));
        exp_rd.push_back('0);
        scrub_en = 1'b1;
        while (exp_rd.size() > 0 && cyc < 80) begin
            #2;
            if (scrub_pass_done) begin
                passes++;
                total++;
                if (!(prev_issue && prev_addr == 4'd15)) begin
                    bad++;
                    $display("FAIL pass_done_timing: got pulse after addr=%0d issue=%0b want after addr=15", prev_addr, prev_issue);
                end
            end
            if (sram_read_en) begin
                e = exp_rd.pop_front();
                total++;
                if (sram_read_addr !== e) begin bad++; $display("FAIL walk_addr: got %0d want %0d", sram_read_addr, e); end
                if (last_t >= 0) begin
                    total++;
                    if (cyc - last_t != 2) begin bad++; $display("FAIL walk_period: got %0d want 2", cyc - last_t); end
                end
                last_t = cyc;
            end
            prev_issue = sram_read_en;
            prev_addr  = sram_read_addr;
            cyc++;
            step;
        end
        total++; if (exp_rd.size() != 0) begin bad++; $display("FAIL walk_timeout: got %0d reads left want 0", exp_rd.size()); exp_rd.delete(); end
        total++; if (passes != 1) begin bad++; $display("FAIL pass_done_count: got %0d want 1", passes); end
    endtask

    task automatic test_client_priority;
        logic [AW-1:0] e;
        for (int i = 0; i < 6; i++) begin
            client_read_en   = 1'b1;
            client_read_addr = AW'(i + 8);
            #2;
            total++;
            if (sram_read_en !== 1'b1 || sram_read_addr !== AW'(i + 8)) begin
                bad++;
                $display("FAIL client_prio: got en=%0b addr=%0d want en=1 addr=%0d", sram_read_en, sram_read_addr, i + 8);
            end
            step;
        end
        client_read_en = 1'b0;
        exp_rd.push_back(4'd1);
        #2;
        e = exp_rd.pop_front();
        total++;
        if (sram_read_en !== 1'b1 || sram_read_addr !== e) begin
            bad++;
            $display("FAIL held_scrub: got en=%0b addr=%0d want en=1 addr=%0d", sram_read_en, sram_read_addr, e);
        end
        step;
    endtask

    task automatic test_scrub_error;
        int cyc = 0;
        logic found = 1'b0;
        entry_t e;
        while (!found && cyc < 80) begin
            #2;
            if (sram_read_en && !client_read_en && sram_read_addr == 4'd5) begin
                sram_ecc_pb_error = 1'b1;
                e.addr = 4'd5; e.src = 1'b1;
                exp_q.push_back(e);
                m_cnt++;
                found = 1'b1;
            end
            step;
            sram_ecc_pb_error = 1'b0;
            cyc++;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL scrub5_timeout: got found=%0b want 1", found); end
        err_pop = 1'b1;
        #2;
        total++; if (err_valid !== 1'b1) begin bad++; $display("FAIL scrub_err_valid: got %0b want 1", err_valid); end
        total++; if (err_count !== 16'(m_cnt)) begin bad++; $display("FAIL scrub_err_count: got %0d want %0d", err_count, m_cnt); end
        total++; if (client_error !== 1'b0) begin bad++; $display("FAIL scrub_client_error: got %0b want 0", client_error); end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (err_addr !== e.addr || err_src !== e.src) begin
                bad++;
                $display("FAIL scrub_entry: got addr=%0d src=%0b want addr=%0d src=%0b", err_addr, err_src, e.addr, e.src);
            end
        end
        step;
        err_pop = 1'b0;
        #2;
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL scrub_drain: got %0b want 0", err_valid); end
        step;
    endtask

    task automatic test_client_error;
        entry_t e;
        client_read_en = 1'b1; client_read_addr = 4'd9; sram_ecc_pb_error = 1'b1;
        e.addr = 4'd9; e.src = 1'b0;
        exp_q.push_back(e);
        m_cnt++;
        #2;
        total++; if (client_error !== 1'b0) begin bad++; $display("FAIL cerr_early: got %0b want 0", client_error); end
        step;
        client_read_en = 1'b0; sram_ecc_pb_error = 1'b0; err_pop = 1'b1;
        #2;
        total++; if (client_error !== 1'b1) begin bad++; $display("FAIL cerr_pulse: got %0b want 1", client_error); end
        total++; if (err_count !== 16'(m_cnt)) begin bad++; $display("FAIL cerr_count: got %0d want %0d", err_count, m_cnt); end
        e = exp_q.pop_front();
        total++;
        if (err_valid !== 1'b1 || err_addr !== e.addr || err_src !== e.src) begin
            bad++;
            $display("FAIL cerr_entry: got v=%0b addr=%0d src=%0b want v=1 addr=%0d src=%0b", err_valid, err_addr, err_src, e.addr, e.src);
        end
        step;
        err_pop = 1'b0;
        #2;
        total++; if (client_error !== 1'b0) begin bad++; $display("FAIL cerr_one_cycle: got %0b want 0", client_error); end
        step;
    endtask

    task automatic test_overflow_clear;
        int n = 0;
        entry_t e;
        err_clear = 1'b1;
        step;
        err_clear = 1'b0;
        m_cnt = 0; m_ovf = 1'b0;
        #2;
        total++; if (err_count !== 16'(m_cnt) || err_overflow !== m_ovf) begin bad++; $display("FAIL clear_alone: got cnt=%0d ovf=%0b want cnt=%0d ovf=%0b", err_count, err_overflow, m_cnt, m_ovf); end
        step;
        for (int i = 1; i <= 6; i++) client_err_cycle(AW'(i), 1'b0);
        #2;
        total++; if (err_count !== 16'(m_cnt)) begin bad++; $display("FAIL ovf_count: got %0d want %0d", err_count, m_cnt); end
        total++; if (err_overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag: got %0b want %0b", err_overflow, m_ovf); end
        step;
        // clear coinciding with a dropped error
        client_read_en = 1'b1; client_read_addr = 4'd10; sram_ecc_pb_error = 1'b1; err_clear = 1'b1;
        m_cnt = 1; m_ovf = (exp_q.size() >= 4);
        step;
        client_read_en = 1'b0; sram_ecc_pb_error = 1'b0; err_clear = 1'b0;
        #2;
        total++; if (err_count !== 16'(m_cnt) || err_overflow !== m_ovf) begin bad++; $display("FAIL clear_with_err: got cnt=%0d ovf=%0b want cnt=%0d ovf=%0b", err_count, err_overflow, m_cnt, m_ovf); end
        step;
        err_clear = 1'b1;
        step;
        err_clear = 1'b0;
        m_cnt = 0; m_ovf = 1'b0;
        client_err_cycle(4'd11, 1'b1);
        #2;
        total++; if (err_count !== 16'(m_cnt) || err_overflow !== m_ovf) begin bad++; $display("FAIL full_push_pop: got cnt=%0d ovf=%0b want cnt=%0d ovf=%0b", err_count, err_overflow, m_cnt, m_ovf); end
        step;
        while (exp_q.size() > 0 && n < 8) begin
            err_pop = 1'b1;
            #2;
            e = exp_q.pop_front();
            total++;
            if (err_valid !== 1'b1 || err_addr !== e.addr || err_src !== e.src) begin
                bad++;
                $display("FAIL drain_entry: got v=%0b addr=%0d src=%0b want v=1 addr=%0d src=%0b", err_valid, err_addr, err_src, e.addr, e.src);
            end
            step;
            n++;
        end
        err_pop = 1'b0;
        #2;
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %0b want 0", err_valid); end
        step;
    endtask

    task automatic test_resume;
        int cyc = 0;
        logic found = 1'b0;
        while (!found && cyc < 80) begin
            #2;
            if (sram_read_en && sram_read_addr == 4'd6) found = 1'b1;
            step;
            cyc++;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL resume_find6: got found=%0b want 1", found); end
        scrub_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++; if (sram_read_en !== 1'b0) begin bad++; $display("FAIL disabled_read: got %0b want 0", sram_read_en); end
            step;
        end
        scrub_en = 1'b1;
        exp_rd.push_back(4'd7);
        cyc = 0; found = 1'b0;
        while (!found && cyc < 20) begin
            #2;
            if (sram_read_en) begin
                found = 1'b1;
                total++;
                if (sram_read_addr !== exp_rd[0]) begin bad++; $display("FAIL resume_addr: got %0d want %0d", sram_read_addr, exp_rd[0]); end
                void'(exp_rd.pop_front());
            end
            step;
            cyc++;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL resume_timeout: got found=%0b want 1", found); exp_rd.delete(); end
    endtask

    task automatic test_reset_mid_wait;
        int cyc = 0;
        int t0 = -1;
        int seen = 0;
        logic found = 1'b0;
        client_err_cycle(4'd3, 1'b0);
        scrub_interval = 16'd3;
        while (!found && cyc < 40) begin
            #2;
            if (sram_read_en) found = 1'b1;
            step;
            cyc++;
        end
        total++; if (found !== 1'b1) begin bad++; $display("FAIL mid_find_issue: got found=%0b want 1", found); end
        reset = 1'b0;
        exp_q.delete(); m_cnt = 0; m_ovf = 1'b0;
        #2;
        total++; if (err_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %0b want 0", err_valid); end
        total++; if (err_count !== 16'(m_cnt)) begin bad++; $display("FAIL mid_rst_count: got %0d want %0d", err_count, m_cnt); end
        total++; if (sram_read_en !== 1'b0 || scrub_pass_done !== 1'b0 || client_error !== 1'b0 || err_overflow !== m_ovf) begin
            bad++;
            $display("FAIL mid_rst_outputs: got en=%0b pd=%0b ce=%0b ovf=%0b want all 0", sram_read_en, scrub_pass_done, client_error, err_overflow);
        end
        reset = 1'b1;
        step;
        exp_rd.push_back(4'd0);
        exp_rd.push_back(4'd1);
        cyc = 0;
        while (seen < 2 && cyc < 40) begin
            #2;
            if (sram_read_en) begin
                total++;
                if (sram_read_addr !== exp_rd[0]) begin bad++; $display("FAIL post_rst_addr: got %0d want %0d", sram_read_addr, exp_rd[0]); end
                void'(exp_rd.pop_front());
                if (t0 >= 0) begin
                    total++;
                    if (cyc - t0 != 5) begin bad++; $display("FAIL interval3_period: got %0d want 5", cyc - t0); end
                end
                t0 = cyc;
                seen++;
            end
            step;
            cyc++;
        end
        total++; if (seen != 2) begin bad++; $display("FAIL post_rst_timeout: got %0d reads want 2", seen); end
    endtask

    initial begin
        test_reset;
        test_scrub_walk;
        test_client_priority;
        test_scrub_error;
        test_client_error;
        test_overflow_clear;
        test_resume;
        test_reset_mid_wait;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
